twiddle_cmul_stage: RTL and testbench
=====================================

// Module: twiddle_cmul_stage
// PURPOSE
//  Complex twiddle multiplier for one radix-2 SDF FFT stage. Sits directly downstream of
//  the 128-entry twiddle ROM and consumes its w_r/w_i/state outputs together with the
//  butterfly output sample. In the twiddle phase it multiplies each sample by the Q8
//  twiddle (256 = 1.0). Otherwise it passes the sample through with identical latency.
// PARAMETERS
//  DATA_W  24  signed width of sample real/imag, in and out
//  TW_W    24  signed width of twiddle real/imag (Q.FRAC)
//  FRAC    8   twiddle fractional bits; product is scaled by 2^-FRAC
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       din_r/din_i/w_r/w_i/state are valid this cycle
//  din_r      in   DATA_W  sample real, signed
//  din_i      in   DATA_W  sample imag, signed
//  w_r        in   TW_W    twiddle real, signed Q.FRAC
//  w_i        in   TW_W    twiddle imag, signed Q.FRAC
//  state      in   2       stage phase: 0 fill, 1 butterfly, 2 twiddle, 3 reserved
//  out_valid  out  1       dout_r/dout_i valid
//  dout_r     out  DATA_W  result real, signed
//  dout_i     out  DATA_W  result imag, signed
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - Reset: out_valid=0, dout_r=0, dout_i=0. All valid-pipeline bits clear on the first
//    rising edge with rst=1. A rst mid-stream flushes in-flight samples; they never appear.
//  - No backpressure: a new sample is accepted on any cycle with in_valid=1.
//  - Fixed latency of 3 cycles. A sample accepted at edge N appears at edge N+3, and
//    out_valid equals in_valid delayed by 3, including gaps.
//  - Data registers load only when their stage valid bit is 1. When out_valid=0, the
//    outputs hold their last value.
//  - Pipeline:
//      S1: register din, w, state.
//      S2: four full-width signed products, DATA_W+TW_W bits each:
//          ar*wr, ai*wi, ar*wi, ai*wr.
//      S3: re = ar*wr - ai*wi and im = ar*wi + ai*wr, each 1 bit wider.
//          Add 2^(FRAC-1) for rounding, then arithmetic shift right by FRAC (floor after
//          the bias, i.e. round half up). Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
//  - Bypass: state!=2 at S1 gives dout = din unchanged, with the same 3-cycle latency.
//    state=3 behaves as bypass.
//  - Mode is taken per sample from its own state, so a phase change between consecutive
//    samples needs no bubble.
//  - w=(-2^FRAC,0) with din=-2^(DATA_W-1) saturates to 2^(DATA_W-1)-1. This is required;
//    no wrap is permitted.
// STRUCTURE
//  - Shared package fft_pkg holds:
//      DATA_W, TW_W, FRAC defaults;
//      phase encodings ST_FILL=2'd0, ST_BFLY=2'd1, ST_TWID=2'd2.
//    The twiddle ROM and the butterfly stage share this package.
//  - One sub-module, cmul_round_sat: combinational round, shift and saturate of one
//    (DATA_W+TW_W+1)-bit sum to DATA_W. It is instantiated twice (re, im).
//  - Top level holds the valid pipeline, the S1..S3 registers and the bypass mux.
// TESTING (defaults DATA_W=24, TW_W=24, FRAC=8)
//  1. Bypass: state=0, din=(1000,-500), w=(0,0)
//     -> 3 cycles later out_valid=1, dout=(1000,-500).
//  2. Unity: state=2, w=(256,0), din=(1234,-77) -> dout=(1234,-77).
//  3. Rotation by -j: state=2, w=(0,-256), din=(100,50) -> dout=(50,-100).
//  4. Rounding: state=2, w=(181,-181), din=(3,0) -> dout=(2,-2).
//  5. Saturation: state=2, w=(181,-181), din=(8388607,8388607) -> dout=(8388607,0).
//     Then din=(-8388608,0), w=(-256,0) -> dout=(8388607,0).
//  6. Stream/reset:
//     - in_valid pattern 1101_1100 with alternating state 1/2 -> out_valid reproduces
//       the pattern shifted 3 cycles, and each result uses its own mode.
//     - rst=1 for one cycle mid-stream -> next cycle out_valid=0 and dout=(0,0); no
//       pre-reset sample emerges afterwards.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 SDF FFT stage blocks (twiddle ROM,
// butterfly, twiddle multiplier).
//   FFT_DATA_W : default signed sample width
//   FFT_TW_W   : default signed twiddle width
//   FFT_FRAC   : default twiddle fractional bits (Q8, 256 = 1.0)
//   fft_state_e: stage phase encoding carried alongside each sample
package fft_pkg;

  localparam int FFT_DATA_W = 24;
  localparam int FFT_TW_W   = 24;
  localparam int FFT_FRAC   = 8;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_BFLY = 2'd1,
    ST_TWID = 2'd2
  } fft_state_e;

endpackage

// File: rtl/cmul_round_sat.sv
// Combinational round-half-up, arithmetic shift by FRAC and saturation of one
// wide signed sum down to DATA_W bits.
//   sum  : in  SUM_W   signed sum of two products
//   dout : out DATA_W  rounded, scaled and saturated result
module cmul_round_sat
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int SUM_W  = FFT_DATA_W + FFT_TW_W + 1,
  parameter int FRAC   = FFT_FRAC
) (
  input  logic signed [SUM_W-1:0]  sum,
  output logic signed [DATA_W-1:0] dout
);

  localparam int SW1 = SUM_W + 1;

  localparam logic signed [SW1-1:0] BIAS = SW1'(1) <<< (FRAC - 1);
  localparam logic signed [SW1-1:0] MAXV = SW1'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [SW1-1:0] MINV = SW1'(signed'({1'b1, {(DATA_W-1){1'b0}}}));

  function automatic logic signed [DATA_W-1:0] round_sat(input logic signed [SUM_W-1:0] s);
    logic signed [SW1-1:0] biased;
    logic signed [SW1-1:0] shifted;
    biased  = SW1'(s) + BIAS;
    shifted = biased >>> FRAC;
    if (shifted > MAXV)
      round_sat = MAXV[DATA_W-1:0];
    else if (shifted < MINV)
      round_sat = MINV[DATA_W-1:0];
    else
      round_sat = shifted[DATA_W-1:0];
  endfunction

  assign dout = round_sat(sum);

endmodule

// File: rtl/twiddle_cmul_stage.sv
// Complex twiddle multiplier for one radix-2 SDF FFT stage. Samples tagged
// ST_TWID are multiplied by the Q.FRAC twiddle; all other phases pass the
// sample through with the same fixed latency of 3 cycles.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid          : din/w/state valid this cycle
//   din_r, din_i      : sample, signed DATA_W
//   w_r, w_i          : twiddle, signed TW_W Q.FRAC
//   state             : stage phase (fft_state_e encoding, 3 = bypass)
//   out_valid         : dout valid
//   dout_r, dout_i    : result, signed DATA_W
module twiddle_cmul_stage
  import fft_pkg::*;
#(
  parameter int DATA_W = FFT_DATA_W,
  parameter int TW_W   = FFT_TW_W,
  parameter int FRAC   = FFT_FRAC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] din_r,
  input  logic signed [DATA_W-1:0] din_i,
  input  logic signed [TW_W-1:0]   w_r,
  input  logic signed [TW_W-1:0]   w_i,
  input  logic        [1:0]        state,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] dout_r,
  output logic signed [DATA_W-1:0] dout_i
);

  localparam int PW = DATA_W + TW_W;
  localparam int SW = PW + 1;

  logic vld_p0, vld_p1, vld_p2;

  logic signed [DATA_W-1:0] ar_p0, ai_p0;
  logic signed [TW_W-1:0]   wr_p0, wi_p0;
  logic        [1:0]        state_p0;

  logic signed [PW-1:0]     prod_rr_p1, prod_ii_p1, prod_ri_p1, prod_ir_p1;
  logic signed [DATA_W-1:0] byp_r_p1, byp_i_p1;
  logic                     twid_p1;

  logic signed [SW-1:0]     re_p2, im_p2;
  logic signed [DATA_W-1:0] byp_r_p2, byp_i_p2;
  logic                     twid_p2;

  logic signed [DATA_W-1:0] rs_r, rs_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      vld_p0    <= in_valid;
      vld_p1    <= vld_p0;
      vld_p2    <= vld_p1;
      out_valid <= vld_p2;
    end
  end

  // S1: capture sample, twiddle and phase
  always_ff @(posedge clk) begin
    if (in_valid) begin
      ar_p0    <= din_r;
      ai_p0    <= din_i;
      wr_p0    <= w_r;
      wi_p0    <= w_i;
      state_p0 <= state;
    end
  end

  // S2: four full-width signed partial products
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      prod_rr_p1 <= PW'(ar_p0) * PW'(wr_p0);
      prod_ii_p1 <= PW'(ai_p0) * PW'(wi_p0);
      prod_ri_p1 <= PW'(ar_p0) * PW'(wi_p0);
      prod_ir_p1 <= PW'(ai_p0) * PW'(wr_p0);
      byp_r_p1   <= ar_p0;
      byp_i_p1   <= ai_p0;
      twid_p1    <= (state_p0 == ST_TWID);
    end
  end

  // S3: complex sums, one bit wider than the products
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      re_p2    <= SW'(prod_rr_p1) - SW'(prod_ii_p1);
      im_p2    <= SW'(prod_ri_p1) + SW'(prod_ir_p1);
      byp_r_p2 <= byp_r_p1;
      byp_i_p2 <= byp_i_p1;
      twid_p2  <= twid_p1;
    end
  end

  cmul_round_sat #(.DATA_W(DATA_W), .SUM_W(SW), .FRAC(FRAC)) u_rs_re (
    .sum  (re_p2),
    .dout (rs_r)
  );

  cmul_round_sat #(.DATA_W(DATA_W), .SUM_W(SW), .FRAC(FRAC)) u_rs_im (
    .sum  (im_p2),
    .dout (rs_i)
  );

  // Output: rounded/saturated product or bypassed sample, held while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r <= '0;
      dout_i <= '0;
    end else if (vld_p2) begin
      dout_r <= twid_p2 ? rs_r : byp_r_p2;
      dout_i <= twid_p2 ? rs_i : byp_i_p2;
    end
  end

endmodule

// File: tb/tb_twiddle_cmul_stage.sv
// Directed self-checking bench for twiddle_cmul_stage (DATA_W=24, TW_W=24, FRAC=8).
module tb_twiddle_cmul_stage;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic signed [23:0]  din_r = '0, din_i = '0;
  logic signed [23:0]  w_r = '0, w_i = '0;
  logic        [1:0]   state = 2'd0;
  logic                out_valid;
  logic signed [23:0]  dout_r, dout_i;

  int n_checks = 0;
  int n_errors = 0;
  int last_r = 0, last_i = 0;

  twiddle_cmul_stage #(.DATA_W(24), .TW_W(24), .FRAC(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .din_r     (din_r),
    .din_i     (din_i),
    .w_r       (w_r),
    .w_i       (w_i),
    .state     (state),
    .out_valid (out_valid),
    .dout_r    (dout_r),
    .dout_i    (dout_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input int st, input int ar, input int ai, input int wr, input int wi);
    in_valid = v;
    state    = 2'(st);
    din_r    = 24'(ar);
    din_i    = 24'(ai);
    w_r      = 24'(wr);
    w_i      = 24'(wi);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One isolated sample: checks the gap before it and the 3-cycle arrival.
  task automatic send_one(input string tag, input int st, input int ar, input int ai,
                          input int wr, input int wi, input int er, input int ei);
    drive(1'b1, st, ar, ai, wr, wi);
    step;
    drive(1'b0, 0, 0, 0, 0, 0);
    step;
    chk({tag, "_vld_n1"}, out_valid, 0);
    step;
    chk({tag, "_vld_n2"}, out_valid, 0);
    step;
    chk({tag, "_vld_n3"}, out_valid, 1);
    chk({tag, "_re"}, dout_r, er);
    chk({tag, "_im"}, dout_i, ei);
    last_r = er;
    last_i = ei;
  endtask

  initial begin
    logic [7:0] pat;
    int exp_r [12];
    int exp_i [12];
    logic exp_v [12];
    int j;

    rst = 1'b1;
    step;
    step;
    chk("rst_vld", out_valid, 0);
    chk("rst_re", dout_r, 0);
    chk("rst_im", dout_i, 0);
    rst = 1'b0;
    step;

    send_one("bypass",  0, 1000, -500, 0, 0, 1000, -500);
    send_one("unity",   2, 1234, -77, 256, 0, 1234, -77);
    send_one("rot_mj",  2, 100, 50, 0, -256, 50, -100);
    send_one("round",   2, 3, 0, 181, -181, 2, -2);
    send_one("sat_pos", 2, 8388607, 8388607, 181, -181, 8388607, 0);
    send_one("sat_neg", 2, -8388608, 0, -256, 0, 8388607, 0);
    send_one("resv3",   3, -42, 17, 256, 0, -42, 17);

    // Gapped stream, alternating bypass (1) and twiddle (2) with w = -j.
    pat = 8'b1101_1100;
    for (int k = 0; k < 12; k++) begin
      exp_v[k] = (k < 8) ? pat[7-k] : 1'b0;
      if (k % 2 == 0) begin
        exp_r[k] = 100 * (k + 1);
        exp_i[k] = -7 * (k + 1);
      end else begin
        exp_r[k] = -7 * (k + 1);
        exp_i[k] = -100 * (k + 1);
      end
    end
    for (int k = 0; k < 12; k++) begin
      drive(exp_v[k], (k % 2 == 0) ? 1 : 2, 100 * (k + 1), -7 * (k + 1), 0, -256);
      step;
      j = k - 3;
      if (j >= 0 && exp_v[j]) begin
        chk("strm_vld", out_valid, 1);
        chk("strm_re", dout_r, exp_r[j]);
        chk("strm_im", dout_i, exp_i[j]);
        last_r = exp_r[j];
        last_i = exp_i[j];
      end else begin
        chk("strm_vld", out_valid, 0);
        chk("strm_hold_re", dout_r, last_r);
        chk("strm_hold_im", dout_i, last_i);
      end
    end

    // Mid-stream reset flushes everything in flight.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1, 500 + k, 600 + k, 0, 0);
      step;
    end
    rst = 1'b1;
    drive(1'b1, 1, 999, 999, 0, 0);
    step;
    rst = 1'b0;
    drive(1'b0, 0, 0, 0, 0, 0);
    chk("mrst_vld", out_valid, 0);
    chk("mrst_re", dout_r, 0);
    chk("mrst_im", dout_i, 0);
    for (int k = 0; k < 5; k++) begin
      step;
      chk("flush_vld", out_valid, 0);
    end
    send_one("post_rst", 2, -300, 200, 0, 256, -200, -300);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
